// File: rtl/i2c_reg_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_reg_seq_if
//  Brief    : Host request/done handshake plus byte-engine command bus
//             for the I2C register-access sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface i2c_reg_seq_if;
    // Host side
    logic        req;
    logic        wr_rd;
    logic [6:0]  dev_addr;
    logic [15:0] reg_addr;
    logic [7:0]  wdata;
    logic        busy;
    logic        done;
    logic        ack_err;
    logic [7:0]  rdata;
    // Byte-engine side
    logic [5:0]  eng_cmd;
    logic        eng_go;
    logic [7:0]  eng_data_tx;
    logic        eng_done;
    logic        eng_ack;
    logic [7:0]  eng_data_rx;

    // Sequencer view
    modport slave (
        input  req, wr_rd, dev_addr, reg_addr, wdata,
        input  eng_done, eng_ack, eng_data_rx,
        output busy, done, ack_err, rdata,
        output eng_cmd, eng_go, eng_data_tx
    );

    // Host + engine view
    modport master (
        output req, wr_rd, dev_addr, reg_addr, wdata,
        output eng_done, eng_ack, eng_data_rx,
        input  busy, done, ack_err, rdata,
        input  eng_cmd, eng_go, eng_data_tx
    );
endinterface
`default_nettype wire

// File: rtl/i2c_reg_seq.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_reg_seq
//  Brief    : Turns one host request into a complete I2C register write or
//             repeated-START register read by sequencing byte-engine steps.
//             Optional macro I2C_ADDR16_EN adds the high register-address byte.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_reg_seq #(
    parameter logic [5:0] CMD_WR_STA = 6'd0,
    parameter logic [5:0] CMD_RD     = 6'd1,
    parameter logic [5:0] CMD_WR     = 6'd2,
    parameter logic [5:0] CMD_STO    = 6'd3,
    parameter logic [5:0] CMD_NACK   = 6'd6
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    i2c_reg_seq_if.slave bus
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_DEV_W = 4'd1;
`ifdef I2C_ADDR16_EN
    localparam logic [3:0] S_REG_H = 4'd2;
`endif
    localparam logic [3:0] S_REG_L = 4'd3;
    localparam logic [3:0] S_WDATA = 4'd4;
    localparam logic [3:0] S_DEV_R = 4'd5;
    localparam logic [3:0] S_RDATA = 4'd6;
    localparam logic [3:0] S_NACK  = 4'd7;
    localparam logic [3:0] S_STOP  = 4'd8;
    localparam logic [3:0] S_FIN   = 4'd9;

    logic [3:0] r_state;
    logic       r_adv;          // engine step finished; advance next cycle
    logic       r_wr_rd;
    logic [6:0] r_dev;
    logic [7:0] r_reg_l;
    logic [7:0] r_wdata;
    logic       r_busy;
    logic       r_done;
    logic       r_ack_err;
    logic [7:0] r_rdata;
    logic [5:0] r_cmd;
    logic       r_go;
    logic [7:0] r_data_tx;
`ifdef I2C_ADDR16_EN
    logic [7:0] r_reg_h;
`else
    logic       w_unused_reg_h;
    assign w_unused_reg_h = ^bus.reg_addr[15:8];
`endif

    logic       w_wr_step;
    logic [3:0] w_next;
    logic [3:0] w_tgt;
    logic [6:0] w_dev;
    logic [5:0] w_tx_cmd;
    logic [7:0] w_tx_data;

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.ack_err     = r_ack_err;
    assign bus.rdata       = r_rdata;
    assign bus.eng_cmd     = r_cmd;
    assign bus.eng_go      = r_go;
    assign bus.eng_data_tx = r_data_tx;

    // Steps whose byte is written by the master and therefore ACK-checked
    always_comb begin
        w_wr_step = 1'b0;
        case (r_state)
            S_DEV_W, S_REG_L, S_WDATA, S_DEV_R: w_wr_step = 1'b1;
`ifdef I2C_ADDR16_EN
            S_REG_H:                            w_wr_step = 1'b1;
`endif
            default:                            w_wr_step = 1'b0;
        endcase
    end

    // A NACK on any written byte diverts straight to STOP so the bus is freed
    always_comb begin
        w_next = S_FIN;
        if (w_wr_step && r_ack_err) begin
            w_next = S_STOP;
        end else begin
            case (r_state)
`ifdef I2C_ADDR16_EN
                S_DEV_W: w_next = S_REG_H;
                S_REG_H: w_next = S_REG_L;
`else
                S_DEV_W: w_next = S_REG_L;
`endif
                S_REG_L: w_next = r_wr_rd ? S_DEV_R : S_WDATA;
                S_WDATA: w_next = S_STOP;
                S_DEV_R: w_next = S_RDATA;
                S_RDATA: w_next = S_NACK;
                S_NACK:  w_next = S_STOP;
                default: w_next = S_FIN;
            endcase
        end
    end

    // Command/data for the step about to be launched; from IDLE the address
    // comes straight from the host inputs because it is latched the same edge.
    always_comb begin
        w_tgt     = r_adv ? w_next : S_DEV_W;
        w_dev     = (r_state == S_IDLE) ? bus.dev_addr : r_dev;
        w_tx_cmd  = CMD_STO;
        w_tx_data = 8'h00;
        case (w_tgt)
            S_DEV_W: begin
                w_tx_cmd  = CMD_WR_STA;
                w_tx_data = {w_dev, 1'b0};
            end
`ifdef I2C_ADDR16_EN
            S_REG_H: begin
                w_tx_cmd  = CMD_WR;
                w_tx_data = r_reg_h;
            end
`endif
            S_REG_L: begin
                w_tx_cmd  = CMD_WR;
                w_tx_data = r_reg_l;
            end
            S_WDATA: begin
                w_tx_cmd  = CMD_WR;
                w_tx_data = r_wdata;
            end
            S_DEV_R: begin
                w_tx_cmd  = CMD_WR_STA;
                w_tx_data = {r_dev, 1'b1};
            end
            S_RDATA: w_tx_cmd = CMD_RD;
            S_NACK:  w_tx_cmd = CMD_NACK;
            default: w_tx_cmd = CMD_STO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_adv     <= 1'b0;
            r_wr_rd   <= 1'b0;
            r_dev     <= 7'd0;
            r_reg_l   <= 8'h00;
            r_wdata   <= 8'h00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_rdata   <= 8'h00;
            r_cmd     <= 6'd0;
            r_go      <= 1'b0;
            r_data_tx <= 8'h00;
`ifdef I2C_ADDR16_EN
            r_reg_h   <= 8'h00;
`endif
        end else begin
            r_go   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_wr_rd   <= bus.wr_rd;
                        r_dev     <= bus.dev_addr;
                        r_reg_l   <= bus.reg_addr[7:0];
`ifdef I2C_ADDR16_EN
                        r_reg_h   <= bus.reg_addr[15:8];
`endif
                        r_wdata   <= bus.wdata;
                        r_ack_err <= 1'b0;
                        r_busy    <= 1'b1;
                        r_adv     <= 1'b0;
                        r_state   <= S_DEV_W;
                        r_go      <= 1'b1;
                        r_cmd     <= w_tx_cmd;
                        r_data_tx <= w_tx_data;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    if (r_adv) begin
                        r_adv <= 1'b0;
                        if (w_next == S_FIN) begin
                            r_state <= S_FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= w_next;
                            r_go      <= 1'b1;
                            r_cmd     <= w_tx_cmd;
                            r_data_tx <= w_tx_data;
                        end
                    end else if (bus.eng_done) begin
                        r_adv <= 1'b1;
                        if (w_wr_step && bus.eng_ack) begin
                            r_ack_err <= 1'b1;
                        end
                        if (r_state == S_RDATA) begin
                            r_rdata <= bus.eng_data_rx;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_reg_seq
//  Brief    : Scoreboard bench: stimulus queues expected engine steps and host
//             results, an engine responder and a done monitor compare them.
// ============================================================================
module tb_i2c_reg_seq;

    typedef struct {
        logic [5:0] cmd;
        logic [7:0] data;
        bit         chk;
        bit         ack;
        logic [7:0] rx;
    } step_t;

    typedef struct {
        bit         ack;
        logic [7:0] rdata;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_reg_seq_if bus ();

    i2c_reg_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    step_t      q_step[$];
    res_t       q_res[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         stop_cyc = 0;
    bit         slow = 1'b0;
    logic [7:0] model_rdata = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic step_t mk(input logic [5:0] c, input logic [7:0] d, input bit chk);
        step_t s;
        s.cmd  = c;
        s.data = d;
        s.chk  = chk;
        s.ack  = 1'b0;
        s.rx   = 8'($urandom);
        return s;
    endfunction

    // Reference: byte list of an I2C register access, truncated at a NACK
    task automatic expect_txn(input bit rd, input logic [6:0] dev, input logic [15:0] ra,
                              input logic [7:0] wd, input int nack_at, input logic [7:0] rx);
        step_t w[$];
        step_t e;
        res_t  r;
        bit    nacked;
        nacked = 1'b0;
        w.push_back(mk(6'd0, {dev, 1'b0}, 1'b1));
`ifdef I2C_ADDR16_EN
        w.push_back(mk(6'd2, ra[15:8], 1'b1));
`endif
        w.push_back(mk(6'd2, ra[7:0], 1'b1));
        if (rd) w.push_back(mk(6'd0, {dev, 1'b1}, 1'b1));
        else    w.push_back(mk(6'd2, wd, 1'b1));
        foreach (w[i]) begin
            if (!nacked) begin
                e = w[i];
                if (i == nack_at) begin
                    e.ack  = 1'b1;
                    nacked = 1'b1;
                end
                q_step.push_back(e);
            end
        end
        if (rd && !nacked) begin
            e = mk(6'd1, 8'h00, 1'b0);
            e.rx = rx;
            q_step.push_back(e);
            q_step.push_back(mk(6'd6, 8'h00, 1'b0));
            model_rdata = rx;
        end
        q_step.push_back(mk(6'd3, 8'h00, 1'b0));
        r.ack   = nacked;
        r.rdata = model_rdata;
        q_res.push_back(r);
    endtask

    task automatic drive_req(input bit rd, input logic [6:0] dev, input logic [15:0] ra,
                             input logic [7:0] wd);
        bus.req      = 1'b1;
        bus.wr_rd    = rd;
        bus.dev_addr = dev;
        bus.reg_addr = ra;
        bus.wdata    = wd;
        @(negedge clk);
        bus.req = 1'b0;
        check("busy_after_accept", bus.busy, 1);
        check("ack_err_cleared", bus.ack_err, 0);
    endtask

    task automatic run_txn(input bit rd, input logic [6:0] dev, input logic [15:0] ra,
                           input logic [7:0] wd, input int nack_at, input logic [7:0] rx,
                           input bit poke);
        int guard;
        expect_txn(rd, dev, ra, wd, nack_at, rx);
        drive_req(rd, dev, ra, wd);
        guard = 0;
        // Scramble host inputs and pulse req while busy: all must be ignored
        while (bus.busy && guard < 3000) begin
            if (poke || $urandom_range(0, 7) == 0) begin
                bus.req      = 1'($urandom_range(0, 1));
                bus.wr_rd    = 1'($urandom);
                bus.dev_addr = 7'($urandom);
                bus.reg_addr = 16'($urandom);
                bus.wdata    = 8'($urandom);
            end
            @(negedge clk);
            guard++;
        end
        bus.req = 1'b0;
        if (guard >= 3000) check("txn_timeout", 1, 0);
        if (poke) begin
            bus.req = 1'b1;
            @(negedge clk);
            bus.req = 1'b0;
            repeat (3) begin
                check("no_requeue_go", bus.eng_go, 0);
                check("no_requeue_busy", bus.busy, 0);
                @(negedge clk);
            end
        end else begin
            @(negedge clk);
        end
    endtask

    // Engine model: consume expected steps, reply after a random delay
    initial begin : engine
        step_t st;
        int    dly;
        bit    aborted;
        bus.eng_done    = 1'b0;
        bus.eng_ack     = 1'b0;
        bus.eng_data_rx = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && bus.eng_go) begin
                if (q_step.size() == 0) begin
                    check("unexpected_eng_go", 1, 0);
                end else begin
                    st = q_step.pop_front();
                    check("eng_cmd", 32'(bus.eng_cmd), 32'(st.cmd));
                    if (st.chk) check("eng_data_tx", 32'(bus.eng_data_tx), 32'(st.data));
                    dly = slow ? 8 : int'($urandom_range(1, 4));
                    aborted = 1'b0;
                    for (int i = 0; i < dly; i++) begin
                        @(negedge clk);
                        if (!rst_n) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (i == 0) check("eng_go_one_cycle", bus.eng_go, 0);
                        check("eng_cmd_stable", 32'(bus.eng_cmd), 32'(st.cmd));
                    end
                    if (!aborted) begin
                        bus.eng_done    = 1'b1;
                        bus.eng_ack     = st.ack;
                        bus.eng_data_rx = st.rx;
                        if (st.cmd == 6'd3) stop_cyc = cyc;
                        @(negedge clk);
                        bus.eng_done    = 1'b0;
                        bus.eng_ack     = 1'b0;
                        bus.eng_data_rx = 8'($urandom);
                    end
                end
            end
        end
    end

    // Host-side monitor: compare each done pulse with the queued result
    initial begin : monitor
        res_t r;
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                if (q_res.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    r = q_res.pop_front();
                    check("ack_err_at_done", bus.ack_err, r.ack);
                    check("rdata_at_done", 32'(bus.rdata), 32'(r.rdata));
                    check("busy_low_at_done", bus.busy, 0);
                    check("done_latency", cyc - stop_cyc, 2);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int guard;
        bit rd;
        int nk;
        bus.req      = 1'b0;
        bus.wr_rd    = 1'b0;
        bus.dev_addr = 7'd0;
        bus.reg_addr = 16'd0;
        bus.wdata    = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_ack_err", bus.ack_err, 0);
        check("rst_rdata", 32'(bus.rdata), 0);
        check("rst_eng_go", bus.eng_go, 0);
        check("rst_eng_cmd", 32'(bus.eng_cmd), 0);
        check("rst_eng_data_tx", 32'(bus.eng_data_tx), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(1'b0, 7'h50, 16'h0012, 8'hA5, -1, 8'h00, 1'b0);
        run_txn(1'b1, 7'h50, 16'h0034, 8'h00, -1, 8'h5C, 1'b0);
        run_txn(1'b0, 7'h50, 16'h0012, 8'h11, 0, 8'h00, 1'b0);
        run_txn(1'b1, 7'h2A, 16'h0056, 8'h00, -1, 8'h3C, 1'b1);
        run_txn(1'b0, 7'h50, 16'hBEEF, 8'h77, -1, 8'h00, 1'b0);

        repeat (40) begin
            rd = 1'($urandom_range(0, 1));
            nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_txn(rd, 7'($urandom), 16'($urandom), 8'($urandom), nk, 8'($urandom),
                    1'($urandom_range(0, 1)));
        end

        // Reset while the read byte is in flight
        slow = 1'b1;
        expect_txn(1'b1, 7'h33, 16'h00C4, 8'h00, -1, 8'hE7);
        drive_req(1'b1, 7'h33, 16'h00C4, 8'h00);
        guard = 0;
        while (!(bus.eng_go && bus.eng_cmd == 6'd1) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) check("reach_rdata_timeout", 1, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_eng_go", bus.eng_go, 0);
        check("midrst_rdata", 32'(bus.rdata), 0);
        check("midrst_done", bus.done, 0);
        check("midrst_eng_cmd", 32'(bus.eng_cmd), 0);
        q_step.delete();
        q_res.delete();
        model_rdata = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        slow = 1'b0;
        @(negedge clk);
        run_txn(1'b1, 7'h19, 16'h0F0E, 8'h00, -1, 8'h96, 1'b0);
        run_txn(1'b0, 7'h19, 16'h0F0E, 8'h42, -1, 8'h00, 1'b0);

        repeat (5) @(negedge clk);
        check("steps_consumed", q_step.size(), 0);
        check("results_consumed", q_res.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
